// File: rtl/borrow_la_pkg.sv
// Shared types and sizing helpers for the sequential borrow-lookahead subtractor.
package borrow_la_pkg;

    localparam int SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice-index register width; at least one bit even for a single-slice build.
    function automatic int idx_w(input int width);
        int n;
        n = width / SLICE;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/borrow_la4.sv
// Combinational 4-bit borrow-lookahead slice: d = a - b - bin, bout = borrow out.
module borrow_la4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g, p;
    logic [4:0] bor;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Two-level lookahead: every internal borrow depends only on g/p and bin.
    assign bor[0] = bin;
    assign bor[1] = g[0] | (p[0] & bin);
    assign bor[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign bor[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & bin);
    assign bor[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d    = a ^ b ^ bor[3:0];
    assign bout = bor[4];

endmodule

// File: rtl/borrow_la_sub_seq.sv
// Multi-cycle A - B - Bin: one 4-bit lookahead slice per clock, LSB first,
// borrow carried between slices in a register. Valid/ready on both sides.
module borrow_la_sub_seq
    import borrow_la_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero
);

    localparam int NSL = WIDTH / SLICE;
    localparam int IW  = idx_w(WIDTH);

    generate
        if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
            $error("borrow_la_sub_seq: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_e           state_q;
    logic [IW-1:0]    idx_q;
    logic             bor_q;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             bout_q, zero_q, out_valid_q;

    logic [3:0]       sl_d;
    logic             sl_bout;
    logic [WIDTH-1:0] diff_nxt;
    logic             last;

    borrow_la4 u_slice (
        .a    (a_q[idx_q*SLICE +: SLICE]),
        .b    (b_q[idx_q*SLICE +: SLICE]),
        .bin  (bor_q),
        .d    (sl_d),
        .bout (sl_bout)
    );

    // Full Diff as it will look after this slice lands; Zero is judged on this.
    always_comb begin
        diff_nxt = diff_q;
        diff_nxt[idx_q*SLICE +: SLICE] = sl_d;
    end

    assign last = (idx_q == IW'(NSL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            bor_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        bor_q   <= Bin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    diff_q <= diff_nxt;
                    bor_q  <= sl_bout;
                    idx_q  <= idx_q + 1'b1;
                    if (last) begin
                        bout_q      <= sl_bout;
                        zero_q      <= (diff_nxt == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_borrow_la_sub_seq.sv
// Directed bench for borrow_la_sub_seq: a 16-bit and a 4-bit instance.
module tb_borrow_la_sub_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        iv16, ir16, ov16, or16, bin16, bo16, z16;
    logic [15:0] a16, b16, d16;
    logic        iv4, ir4, ov4, or4, bin4, bo4, z4;
    logic [3:0]  a4, b4, d4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    borrow_la_sub_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .Bin(bin16), .out_valid(ov16), .out_ready(or16),
        .Diff(d16), .Bout(bo16), .Zero(z16)
    );

    borrow_la_sub_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .A(a4), .B(b4), .Bin(bin4), .out_valid(ov4), .out_ready(or4),
        .Diff(d4), .Bout(bo4), .Zero(z4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation on the 16-bit instance and wait for out_valid.
    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic bi,
                           input string tag);
        int n;
        check({tag, "_in_ready"}, 32'(ir16), 32'd1);
        a16 = a; b16 = b; bin16 = bi; iv16 = 1'b1;
        step();
        iv16 = 1'b0;
        n = 0;
        while (!ov16 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
    endtask

    task automatic finish16(input logic [15:0] ed, input logic eb, input logic ez,
                            input string tag);
        check({tag, "_diff"}, 32'(d16), 32'(ed));
        check({tag, "_bout"}, 32'(bo16), 32'(eb));
        check({tag, "_zero"}, 32'(z16), 32'(ez));
        check({tag, "_busy"}, 32'(ir16), 32'd0);
        or16 = 1'b1;
        step();
        or16 = 1'b0;
        check({tag, "_drop"}, {30'd0, ov16, ir16}, 32'b01);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] ed,
                       input logic eb, input string tag);
        int n;
        a4 = a; b4 = b; bin4 = 1'b0; iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        n = 0;
        while (!ov4 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd1);
        check({tag, "_diff"}, 32'(d4), 32'(ed));
        check({tag, "_bout"}, 32'(bo4), 32'(eb));
        or4 = 1'b1;
        step();
        or4 = 1'b0;
        check({tag, "_drop"}, {30'd0, ov4, ir4}, 32'b01);
    endtask

    initial begin
        rst_n = 1'b0;
        iv16 = 0; or16 = 0; a16 = '0; b16 = '0; bin16 = 0;
        iv4 = 0; or4 = 0; a4 = '0; b4 = '0; bin4 = 0;
        #12;
        check("rst_state", {27'd0, ir16, ov16, bo16, z16, 1'b0}, {27'd0, 5'b10000});
        check("rst_diff", 32'(d16), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        start16(16'h0002, 16'h0006, 1'b0, "neg");
        finish16(16'hFFFC, 1'b1, 1'b0, "neg");

        start16(16'hBEEF, 16'hBEEF, 1'b0, "eq");
        finish16(16'h0000, 1'b0, 1'b1, "eq");

        start16(16'h0000, 16'h0000, 1'b1, "bin0");
        finish16(16'hFFFF, 1'b1, 1'b0, "bin0");

        start16(16'hFFFF, 16'hFFFF, 1'b1, "binF");
        finish16(16'hFFFF, 1'b1, 1'b0, "binF");

        // Backpressure: held in DONE while a new operand set is offered.
        start16(16'h1234, 16'h0234, 1'b0, "bp");
        a16 = 16'h0005; b16 = 16'h0003; bin16 = 1'b0; iv16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold", {13'd0, ov16, ir16, z16, d16}, {13'd0, 3'b100, 16'h1000});
        end
        iv16 = 1'b0;
        finish16(16'h1000, 1'b0, 1'b0, "bp");
        start16(16'h0005, 16'h0003, 1'b0, "bp_next");
        finish16(16'h0002, 1'b0, 1'b0, "bp_next");

        // Abort after two slices with an asynchronous reset between edges.
        a16 = 16'h0000; b16 = 16'h0001; bin16 = 1'b0; iv16 = 1'b1;
        step();
        iv16 = 1'b0;
        step();
        step();
        check("abort_partial", 32'(d16), 32'h0000_00FF);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rst", {14'd0, ov16, ir16, d16}, {14'd0, 2'b01, 16'h0000});
        #3 rst_n = 1'b1;
        step();
        check("abort_no_result", 32'(ov16), 32'd0);
        start16(16'h000A, 16'h000C, 1'b0, "post_rst");
        finish16(16'hFFFE, 1'b1, 1'b0, "post_rst");

        op4(4'hA, 4'hC, 4'hE, 1'b1, "w4_a");
        op4(4'hF, 4'h1, 4'hE, 1'b0, "w4_b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/borrow_la_sub_seq.md
Name: borrow_la_sub_seq

Overview:
Multi-cycle N-bit subtractor computing A - B - Bin. It is the inverse companion of the team's 4-bit carry-lookahead adder. One 4-bit borrow-lookahead slice is evaluated per clock, LSB slice first, with the borrow rippling through a register between slices. Valid/ready handshakes on input and output let it sit between a producer and a consumer in the arithmetic datapath.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4 (elaboration error otherwise).
SLICE, 4, bits processed per cycle; fixed, not to be overridden.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands on A/B/Bin are valid.
in_ready  output  1  block can accept operands.
A  input  WIDTH  minuend.
B  input  WIDTH  subtrahend.
Bin  input  1  borrow-in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
Diff  output  WIDTH  A - B - Bin modulo 2^WIDTH.
Bout  output  1  borrow-out: 1 when A < B + Bin (unsigned).
Zero  output  1  Diff == 0.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following state, independent of clk:
  - state IDLE, slice index 0, borrow register 0;
  - out_valid 0, Diff 0, Bout 0, Zero 0;
  - in_ready 1 (decoded from IDLE).
- Reset asserted mid-operation aborts that operation. No result is produced for it.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture A, B and Bin into operand registers, set idx=0, go to RUN.
  - RUN: in_ready=0. Each cycle, evaluate slice idx from captured A[idx*4+:4], B[idx*4+:4] and the borrow register. Write the slice result into Diff[idx*4+:4], load the slice borrow-out into the borrow register, and increment idx. When idx == WIDTH/4-1, also load Bout with the slice borrow-out, load Zero with (full next Diff == 0), and go to DONE.
  - DONE: out_valid=1, in_ready=0. Diff, Bout and Zero are held stable. On out_ready go to IDLE, where out_valid=0 on the next cycle.
- Slice logic (4-bit borrow lookahead):
  - g_i = ~a_i & b_i; p_i = ~(a_i ^ b_i).
  - b_{i+1} = g_i | (p_i & b_i), expanded to two-level lookahead for all 4 bits.
  - d_i = a_i ^ b_i ^ bor_i.
- Latency: accept edge at cycle 0; out_valid is high after WIDTH/4 further edges (4 for WIDTH=16, 1 for WIDTH=4).
- Throughput: one operation per WIDTH/4+2 cycles minimum. No overlap.
- in_valid is ignored outside IDLE, and operand changes during RUN/DONE have no effect.
- out_ready is ignored outside DONE.
- Diff is visible but partial during RUN. Consumers use it only when out_valid=1.
- In-flight accepts are impossible: in_ready and out_valid are never both high.

Decomposition:
- Shared package borrow_la_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparam SLICE=4;
  - a function giving the index width, clog2(WIDTH/4) with a minimum of 1.
- One sub-module, borrow_la4: purely combinational 4-bit borrow-lookahead slice, ports a[4], b[4], bin -> d[4], bout. It is instantiated once and reused every cycle via the index mux.

Test Plan:
- WIDTH=16: A=0x0002, B=0x0006, Bin=0 -> Diff=0xFFFC, Bout=1, Zero=0; out_valid exactly 4 edges after accept.
- A=0x1234, B=0x0234, Bin=0 -> Diff=0x1000, Bout=0, Zero=0. A=B=0xBEEF -> Diff=0x0000, Bout=0, Zero=1.
- Borrow-in through all slices: A=0x0000, B=0x0000, Bin=1 -> Diff=0xFFFF, Bout=1. A=0xFFFF, B=0xFFFF, Bin=1 -> Diff=0xFFFF, Bout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands applied -> outputs stable, in_ready=0, no second capture. Release out_ready -> IDLE, then next operands accepted.
- Reset mid-RUN: pulse rst_n low after 2 slices, asynchronously, between edges -> out_valid=0, Diff=0 immediately, in_ready=1. A subsequent A=0x000A, B=0x000C completes with Diff=0xFFFE, Bout=1.
- WIDTH=4 instance, reusing adder vectors as subtraction: A=0xA, B=0xC -> Diff=0xE, Bout=1; A=0xF, B=0x1 -> Diff=0xE, Bout=0. Each takes 1 RUN cycle.
